// File: rtl/jtshouse_mmr_pkg.sv
// Shared types for the scroll MMR restore loader.
//   MMR_SIZE / MMR_AW : register file size and index width
//   ld_state_t        : loader FSM states
//   mmr_entry_t       : one buffered restore byte {index, data}
package jtshouse_mmr_pkg;

   localparam int MMR_SIZE = 32;
   localparam int MMR_AW   = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_VERIFY,
      ST_CHECK
   } ld_state_t;

   typedef struct packed {
      logic [MMR_AW-1:0] idx;
      logic [7:0]        data;
   } mmr_entry_t;

endpackage

// File: rtl/jtshouse_mmr_fifo.sv
// Small synchronous FIFO of restore entries.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and entry; ignored when full unless popping too
//   pop        : remove head (ignored when empty)
//   dout       : current head entry (valid while !empty)
//   full, empty, level : occupancy flags and count
module jtshouse_mmr_fifo
   import jtshouse_mmr_pkg::*;
#(
   parameter int AW = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  mmr_entry_t  din,
   input  logic        pop,
   output mmr_entry_t  dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   localparam int DEPTH = 1 << AW;

   mmr_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign level   = cnt;
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define validity,
   // and leaving the array out of reset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtshouse_mmr_loader.sv
// Restore-side writer for the scroll MMR register file.
// Captures ioctl download bytes in the MMR window, buffers them and writes
// them into the MMR over the CPU-side bus, optionally reading each back.
//   clk, rst_n          : clock, synchronous active-low reset
//   ioctl_ram/wr/addr/dout : restore download stream
//   cpu_cs/addr/rnw/din : CPU bus (always has priority); cpu_dout = mmr_dout
//   mmr_cs/addr/rnw/din : muxed bus to the MMR; mmr_dout is its read data
//   busy  : work pending;  done : window closed and drained (sticky)
//   ovf   : byte dropped on full FIFO (sticky);  mism : saturating mismatch count
module jtshouse_mmr_loader
   import jtshouse_mmr_pkg::*;
#(
   parameter int BASE    = 0,
   parameter int SIZE    = 32,
   parameter int FIFO_AW = 2,
   parameter int VERIFY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ioctl_ram,
   input  logic              ioctl_wr,
   input  logic [25:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              cpu_cs,
   input  logic [MMR_AW-1:0] cpu_addr,
   input  logic              cpu_rnw,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              mmr_cs,
   output logic [MMR_AW-1:0] mmr_addr,
   output logic              mmr_rnw,
   output logic [7:0]        mmr_din,
   input  logic [7:0]        mmr_dout,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [7:0]        mism
);

   localparam logic [FIFO_AW:0] LEVEL_ONE = 1;

   ld_state_t         state;
   mmr_entry_t        lat;
   mmr_entry_t        head;
   mmr_entry_t        push_entry;
   logic              ram_q;
   logic [25:0]       rel;
   logic              capture;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_AW:0]  fifo_level;
   logic              ovf_evt;
   logic              more;
   logic              ld_cs;
   logic              ld_rnw;
   logic [MMR_AW-1:0] ld_addr;
   logic [7:0]        ld_din;

   // Offset into the MMR image; addresses below BASE wrap to huge values and
   // fall out of range, so one unsigned compare covers both bounds.
   assign rel        = ioctl_addr - 26'(BASE);
   assign capture    = ioctl_wr & ioctl_ram & (rel < 26'(SIZE));
   assign push_entry = '{idx: rel[MMR_AW-1:0], data: ioctl_dout};
   assign fifo_pop   = (state == ST_WRITE) & ~cpu_cs;
   assign ovf_evt    = capture & fifo_full & ~fifo_pop;
   // Without readback the loader can chain writes while entries remain.
   assign more       = (fifo_level > LEVEL_ONE) | capture;

   jtshouse_mmr_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      ld_cs   = 1'b0;
      ld_rnw  = 1'b0;
      ld_addr = '0;
      ld_din  = '0;
      case (state)
         ST_WRITE: begin
            ld_cs   = 1'b1;
            ld_addr = head.idx;
            ld_din  = head.data;
         end
         ST_VERIFY: begin
            ld_cs   = 1'b1;
            ld_rnw  = 1'b1;
            ld_addr = lat.idx;
         end
         default: ;
      endcase
   end

   always_comb begin
      if (cpu_cs) begin
         mmr_cs   = cpu_cs;
         mmr_addr = cpu_addr;
         mmr_rnw  = cpu_rnw;
         mmr_din  = cpu_din;
      end else begin
         mmr_cs   = ld_cs;
         mmr_addr = ld_addr;
         mmr_rnw  = ld_rnw;
         mmr_din  = ld_din;
      end
   end

   assign cpu_dout = mmr_dout;
   assign busy     = ~fifo_empty | (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         lat   <= '0;
         ram_q <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         mism  <= '0;
      end else begin
         ram_q <= ioctl_ram;
         case (state)
            ST_IDLE:
               if (!fifo_empty) state <= ST_WRITE;
            ST_WRITE:
               // A CPU access steals the bus; retry with the head still queued.
               if (!cpu_cs) begin
                  lat <= head;
                  if (VERIFY != 0) state <= ST_VERIFY;
                  else if (more)   state <= ST_WRITE;
                  else             state <= ST_IDLE;
               end
            ST_VERIFY:
               if (!cpu_cs) state <= ST_CHECK;
            ST_CHECK: begin
               // mmr_dout now holds the registered read issued in VERIFY.
               if (mmr_dout != lat.data && mism != 8'hFF) mism <= mism + 8'd1;
               state <= ST_IDLE;
            end
            default:
               state <= ST_IDLE;
         endcase

         // A new restore window starts fresh status; the FIFO is kept.
         if (ioctl_ram && !ram_q) begin
            done <= 1'b0;
            ovf  <= 1'b0;
            mism <= '0;
         end
         if (ovf_evt) ovf <= 1'b1;
         if (!ioctl_ram && fifo_empty && state == ST_IDLE) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtshouse_mmr_loader.sv
// Self-checking bench for jtshouse_mmr_loader: a behavioural MMR, an
// expected-write scoreboard fed by the stimulus, and a monitor that checks
// every loader write on the bus against it.
module tb_jtshouse_mmr_loader;

   localparam int BASE = 8;
   localparam int N    = 32;

   logic        clk;
   logic        rst_n;
   logic        ioctl_ram;
   logic        ioctl_wr;
   logic [25:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        cpu_cs;
   logic [4:0]  cpu_addr;
   logic        cpu_rnw;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        mmr_cs;
   logic [4:0]  mmr_addr;
   logic        mmr_rnw;
   logic [7:0]  mmr_din;
   logic [7:0]  mmr_dout;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [7:0]  mism;

   jtshouse_mmr_loader #(.BASE(BASE), .SIZE(N), .FIFO_AW(2), .VERIFY(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ioctl_ram  (ioctl_ram),
      .ioctl_wr   (ioctl_wr),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .cpu_cs     (cpu_cs),
      .cpu_addr   (cpu_addr),
      .cpu_rnw    (cpu_rnw),
      .cpu_din    (cpu_din),
      .cpu_dout   (cpu_dout),
      .mmr_cs     (mmr_cs),
      .mmr_addr   (mmr_addr),
      .mmr_rnw    (mmr_rnw),
      .mmr_din    (mmr_din),
      .mmr_dout   (mmr_dout),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf),
      .mism       (mism)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MMR: write on cs & !rnw, registered read one cycle later.
   logic [7:0] mem     [N];
   logic [7:0] ref_mem [N];
   logic [7:0] rd_q;
   logic       stuck;

   always @(posedge clk) begin
      if (mmr_cs) begin
         if (!mmr_rnw) mem[mmr_addr] <= mmr_din;
         rd_q <= mem[mmr_addr];
      end
   end
   assign mmr_dout = stuck ? 8'h00 : rd_q;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int idx;
      int data;
   } exp_t;
   exp_t exp_q[$];
   int   last_wr_cyc = -1;
   int   last_wr_idx = -1;

   // Monitor: every loader-driven write must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && mmr_cs && !mmr_rnw && !cpu_cs) begin
         last_wr_cyc = cyc;
         last_wr_idx = int'(mmr_addr);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: idx=%0d data=%0d with none expected", mmr_addr, mmr_din);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_idx", 32'(mmr_addr), e.idx);
            check("wr_data", 32'(mmr_din), e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One download byte; accept says whether the spec rules admit it.
   task automatic send(input int addr, input logic [7:0] d, input bit accept);
      exp_t e;
      ioctl_addr = 26'(addr);
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      if (accept) begin
         e.idx  = addr - BASE;
         e.data = int'(d);
         exp_q.push_back(e);
         ref_mem[addr - BASE] = d;
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) tick();
      check("drain_busy", 32'(busy), 0);
   endtask

   task automatic open_window();
      ioctl_ram = 1'b0;
      tick();
      ioctl_ram = 1'b1;
      tick();
      check("open_done", 32'(done), 0);
      check("open_ovf", 32'(ovf), 0);
      check("open_mism", 32'(mism), 0);
   endtask

   task automatic close_window();
      ioctl_ram = 1'b0;
      wait_idle(400);
      tick();
      tick();
      check("close_done", 32'(done), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   start;
      int   release_cyc;
      bit   seen;

      rst_n      = 1'b0;
      ioctl_ram  = 1'b0;
      ioctl_wr   = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      stuck      = 1'b0;
      rd_q       = '0;
      for (int i = 0; i < N; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end

      // Reset state, with the CPU reading so the mux passes it through.
      cpu_cs   = 1'b1;
      cpu_rnw  = 1'b1;
      cpu_addr = 5'($urandom);
      cpu_din  = 8'($urandom);
      tick();
      tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_mism", 32'(mism), 0);
      check("rst_mmr_cs", 32'(mmr_cs), 32'(cpu_cs));
      check("rst_mmr_addr", 32'(mmr_addr), 32'(cpu_addr));
      check("rst_mmr_rnw", 32'(mmr_rnw), 32'(cpu_rnw));
      check("rst_mmr_din", 32'(mmr_din), 32'(cpu_din));
      check("cpu_dout_pass", 32'(cpu_dout), 32'(mmr_dout));
      rst_n    = 1'b1;
      cpu_cs   = 1'b0;
      cpu_rnw  = 1'b0;
      cpu_addr = '0;
      cpu_din  = '0;
      tick();
      check("idle_no_drive", 32'(mmr_cs), 0);

      // Full image in order, data = idx ^ 5A, one byte every 4 cycles.
      open_window();
      for (int i = 0; i < N; i++) begin
         send(BASE + i, 8'(i) ^ 8'h5A, 1'b1);
         repeat (3) tick();
      end
      close_window();
      check("stream_ovf", 32'(ovf), 0);
      check("stream_mism", 32'(mism), 0);

      // Random in-range bytes with random spacing of at least 4 cycles.
      open_window();
      n = 20 + int'($urandom_range(0, 9));
      for (int i = 0; i < n; i++) begin
         send(BASE + int'($urandom_range(0, N - 1)), 8'($urandom), 1'b1);
         repeat (3 + $urandom_range(0, 3)) tick();
      end
      close_window();
      check("rand_ovf", 32'(ovf), 0);
      check("rand_mism", 32'(mism), 0);

      // Six back-to-back bytes from empty: four fill the FIFO, one more fits
      // after the first pop, the sixth arrives while full with no pop.
      open_window();
      start = int'($urandom_range(0, N - 1));
      for (int k = 0; k < 6; k++) begin
         exp_t e;
         ioctl_addr = 26'(BASE + (start + 5 * k) % N);
         ioctl_dout = 8'($urandom);
         ioctl_wr   = 1'b1;
         if (k < 5) begin
            e.idx  = (start + 5 * k) % N;
            e.data = int'(ioctl_dout);
            exp_q.push_back(e);
            ref_mem[e.idx] = ioctl_dout;
         end
         tick();
      end
      ioctl_wr = 1'b0;
      close_window();
      check("burst_ovf", 32'(ovf), 1);

      // CPU holds the bus on a read of index 3 while index 7 is pending.
      open_window();
      cpu_cs  = 1'b1;
      cpu_rnw = 1'b1;
      cpu_addr = 5'd3;
      send(BASE + 7, 8'($urandom), 1'b1);
      for (int i = 0; i < 10; i++) begin
         check("hold_addr", 32'(mmr_addr), 3);
         check("hold_rnw", 32'(mmr_rnw), 1);
         tick();
      end
      cpu_cs      = 1'b0;
      cpu_rnw     = 1'b0;
      cpu_addr    = '0;
      release_cyc = cyc;
      repeat (3) tick();
      check("hold_wr_cycle", 32'(last_wr_cyc), 32'(release_cyc));
      check("hold_wr_idx", 32'(last_wr_idx), 7);
      close_window();

      // Readback stuck at zero: every FF write miscompares.
      open_window();
      stuck = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(BASE + i, 8'hFF, 1'b1);
         repeat (3) tick();
      end
      close_window();
      check("mism_3", 32'(mism), 3);
      open_window();
      for (int i = 0; i < 300; i++) begin
         send(BASE + int'($urandom_range(0, N - 1)), 8'hFF, 1'b1);
         repeat (3) tick();
      end
      close_window();
      check("mism_sat", 32'(mism), 255);
      stuck = 1'b0;

      // Reset while the loader is reading back.
      open_window();
      send(BASE + 9, 8'($urandom), 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (mmr_cs && mmr_rnw && !cpu_cs) seen = 1'b1;
         else tick();
      end
      check("saw_verify", 32'(seen), 1);
      rst_n    = 1'b0;
      cpu_cs   = 1'b1;
      cpu_rnw  = 1'b1;
      cpu_addr = 5'($urandom);
      cpu_din  = 8'($urandom);
      tick();
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_mmr_addr", 32'(mmr_addr), 32'(cpu_addr));
      check("mid_rst_mmr_din", 32'(mmr_din), 32'(cpu_din));
      check("mid_rst_mmr_rnw", 32'(mmr_rnw), 1);
      rst_n    = 1'b1;
      cpu_cs   = 1'b0;
      cpu_rnw  = 1'b0;
      cpu_addr = '0;
      cpu_din  = '0;
      tick();
      check("post_rst_no_drive", 32'(mmr_cs), 0);

      // Just outside the window on both sides: nothing captured.
      send(BASE + N, 8'($urandom), 1'b0);
      send(BASE - 1, 8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("oor_busy", 32'(busy), 0);
         tick();
      end
      close_window();

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      for (int i = 0; i < N; i++) check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
